ins_queue: RTL and testbench

INS_QUEUE -- requirements
Module: ins_queue

---
 rtl/ins_queue.sv | 81 ++++++++
 tb/tb_ins_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ins_queue.sv
// Instruction queue between the align stage and the decoder: a DEPTH-entry
// first-word-fall-through circular buffer with flush and squash-drop on input.
module ins_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 144
) (
    input  logic                     cpu_clk_i,
    input  logic                     cpu_rst_i,
    input  logic                     flush_i,
    input  logic                     in_vld_i,
    input  logic [DW-1:0]            in_pkt_i,
    output logic                     busy_o,
    output logic                     out_vld_o,
    output logic [DW-1:0]            out_pkt_o,
    input  logic                     out_rdy_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Valid-flag positions inside the packet (layout is fixed, invalidate at bit 0)
    localparam int unsigned INS0_VLD_BIT  = 110;
    localparam int unsigned INS1_VLD_BIT  = 76;
    localparam int unsigned EXCP_VLD_BIT  = 40;
    localparam int unsigned INVAL_BIT     = 0;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic full_c;
    logic empty_c;
    logic squash_c;
    logic push_c;
    logic pop_c;

    // Pointer compare, handshakes and next-pointer computation
    always_comb begin
        full_c   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty_c  = (wr_ptr_q == rd_ptr_q);
        squash_c = !in_pkt_i[INS0_VLD_BIT] && !in_pkt_i[INS1_VLD_BIT]
                && !in_pkt_i[EXCP_VLD_BIT] && !in_pkt_i[INVAL_BIT];
        push_c   = in_vld_i && !full_c && !flush_i && !squash_c;
        pop_c    = !empty_c && out_rdy_i && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never cleared; only pointers carry state validity
    always_ff @(posedge cpu_clk_i) begin
        if (!cpu_rst_i && push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_pkt_i;
        end
    end

    always_comb begin
        busy_o    = full_c;
        out_vld_o = !empty_c;
        out_pkt_o = mem_q[rd_ptr_q[AW-1:0]];
        count_o   = wr_ptr_q - rd_ptr_q;
    end

endmodule

// File: tb/tb_ins_queue.sv
// Scoreboard bench for ins_queue: stimulus queues expected packets, a forked
// monitor compares the head packet whenever the queue presents one.
module tb_ins_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 144;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_vld;
    logic [DW-1:0] in_pkt;
    logic          busy;
    logic          out_vld;
    logic [DW-1:0] out_pkt;
    logic          out_rdy;
    logic [2:0]    count;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    ins_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .cpu_clk_i (clk),
        .cpu_rst_i (rst),
        .flush_i   (flush),
        .in_vld_i  (in_vld),
        .in_pkt_i  (in_pkt),
        .busy_o    (busy),
        .out_vld_o (out_vld),
        .out_pkt_o (out_pkt),
        .out_rdy_i (out_rdy),
        .count_o   (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic i0v, input logic ev, input logic inv,
                                         input logic [30:0] vpc, input logic [31:0] tag);
        logic [DW-1:0] p;
        p          = '0;
        p[143:112] = tag;
        p[110]     = i0v;
        p[109:78]  = ~tag;
        p[75:45]   = vpc;
        p[40]      = ev;
        p[33:3]    = vpc ^ 31'h5a5a;
        p[0]       = inv;
        return p;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input int c, input logic v, input logic b);
        chk({name, ".count"}, DW'(count), DW'(c));
        chk({name, ".vld"}, DW'(out_vld), DW'(v));
        chk({name, ".busy"}, DW'(busy), DW'(b));
    endtask

    // Drive one cycle of inputs; acc is the hand-computed acceptance of the packet
    task automatic drive(input logic r, input logic fl, input logic v, input logic [DW-1:0] p,
                         input logic rdy, input logic acc);
        rst = r; flush = fl; in_vld = v; in_pkt = p; out_rdy = rdy;
        if (r || fl) exp_q.delete();
        if (acc) exp_q.push_back(p);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon.unexpected: out_vld=1 pkt %h with empty scoreboard", out_pkt);
                end else begin
                    chk("mon.head", out_pkt, exp_q[0]);
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] idle_p;
        logic [DW-1:0] pa;
        idle_p = '0;
        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_pkt = '0; out_rdy = 1'b0;
        fork
            monitor();
        join_none

        // Reset with a packet presented: must be discarded
        drive(1'b1, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h7, 32'hdead), 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h7, 32'hdead), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, idle_p, 1'b0, 1'b0);
        chk_status("reset", 0, 1'b0, 1'b0);

        // Single push, latency one cycle
        pa = mk(1'b1, 1'b0, 1'b0, 31'h100, 32'ha);
        drive(1'b0, 1'b0, 1'b1, pa, 1'b0, 1'b1);
        chk_status("push_a", 1, 1'b1, 1'b0);
        chk("push_a.pkt", out_pkt, pa);

        // Fill to DEPTH, then the 5th is held until a pop frees a slot
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h104, 32'hb), 1'b0, 1'b1);
        chk_status("fill2", 2, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h108, 32'hc), 1'b0, 1'b1);
        chk_status("fill3", 3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h10c, 32'hd), 1'b0, 1'b1);
        chk_status("fill4", 4, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h110, 32'he), 1'b0, 1'b0);
        chk_status("full_hold", 4, 1'b1, 1'b1);
        chk("full_hold.pkt", out_pkt, pa);
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h110, 32'he), 1'b1, 1'b0);
        chk_status("full_pop", 3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h110, 32'he), 1'b0, 1'b1);
        chk_status("fifth_in", 4, 1'b1, 1'b1);

        // Flush while full with a packet presented
        drive(1'b0, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h200, 32'hf), 1'b1, 1'b0);
        chk_status("flush", 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, idle_p, 1'b0, 1'b0);
        chk_status("flush_after", 0, 1'b0, 1'b0);

        // Squashed packet dropped; excp-only and invalidate-only packets kept
        drive(1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 31'h300, 32'h5), 1'b0, 1'b0);
        chk_status("squash", 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 31'h304, 32'h6), 1'b0, 1'b1);
        chk_status("excp_only", 1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b1, 31'h308, 32'h7), 1'b0, 1'b1);
        chk_status("inval_only", 2, 1'b1, 1'b0);

        // Steady push+pop at occupancy 2, wrapping pointers several times
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h400 + 31'(i * 4), 32'h100 + 32'(i)),
                  1'b1, 1'b1);
            chk_status("stream", 2, 1'b1, 1'b0);
        end

        // Reset mid-stream at occupancy 3 with a packet presented
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h500, 32'h200), 1'b0, 1'b1);
        chk_status("pre_rst", 3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h504, 32'h201), 1'b1, 1'b0);
        chk_status("mid_rst", 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, idle_p, 1'b0, 1'b0);
        chk_status("post_rst", 0, 1'b0, 1'b0);

        // Queue still functional after reset
        drive(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 31'h600, 32'h300), 1'b0, 1'b1);
        chk_status("re_push", 1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, idle_p, 1'b1, 1'b0);
        chk_status("re_pop", 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, idle_p, 1'b0, 1'b0);
        chk("scoreboard_drained", DW'(exp_q.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
